// File: rtl/main_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
// The master drives the instruction fields and memory handshake; the slave returns state and control.
interface main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;

    logic [3:0] State;
    logic       IRWrite;
    logic       AdrSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;

    modport master (
        output Op, Funct, MemReady,
        input  State, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
        input  ALUSrcA, ALUSrcB, ResultSrc
    );

    modport slave (
        input  Op, Funct, MemReady,
        output State, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
        output ALUSrcA, ALUSrcB, ResultSrc
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle processor main controller: Moore FSM with registered control outputs.
// IRWrite/NextPC are the only Mealy terms, so each fetch yields exactly one PC increment.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t f_moore(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH, DECODE: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            MEMADR: begin
                c.alu_src_a = 2'b00;
                c.alu_src_b = 2'b01;
            end
            MEMRD: begin
                c.adr_src    = 1'b1;
                c.result_src = 2'b00;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            EXECUTER: begin
                c.alu_src_a = 2'b00;
                c.alu_src_b = 2'b00;
                c.alu_op    = 1'b1;
            end
            EXECUTEI: begin
                c.alu_src_a = 2'b00;
                c.alu_src_b = 2'b01;
                c.alu_op    = 1'b1;
            end
            ALUWB: begin
                c.result_src = 2'b00;
                c.reg_w      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Op/Funct only matter in DECODE and MEMADR; every other state ignores them.
    function automatic state_t f_next(input state_t s, input logic [1:0] op,
                                      input logic imm, input logic load,
                                      input logic mem_ready);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:    n = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    2'b00:   n = imm ? EXECUTEI : EXECUTER;
                    2'b01:   n = MEMADR;
                    2'b10:   n = BRANCH;
                    default: n = FETCH;
                endcase
            end
            MEMADR:   n = load ? MEMRD : MEMWR;
            MEMRD:    n = mem_ready ? MEMWB : MEMRD;
            MEMWR:    n = mem_ready ? FETCH : MEMWR;
            EXECUTER: n = ALUWB;
            EXECUTEI: n = ALUWB;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    logic   w_state_legal;
    logic   w_fetch_grant;
    logic   w_unused_funct;

    assign w_next = f_next(r_state, bus.Op, bus.Funct[5], bus.Funct[0], bus.MemReady);
    assign w_unused_funct = ^bus.Funct[4:1];

    // NOTE: the output register is loaded with the value for the state being
    // entered, so outputs change together with State and stay glitch-free.
    // Non-blocking assignments keep state and outputs updating in lockstep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= f_moore(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_moore(w_next);
        end
    end

    // An encoding outside 0..9 can only appear through an upset; keep it silent.
    assign w_state_legal = (r_state <= BRANCH);
    assign w_fetch_grant = (r_state == FETCH) && !reset && bus.MemReady;

    assign bus.State     = r_state;
    assign bus.IRWrite   = w_fetch_grant;
    assign bus.NextPC    = w_fetch_grant;
    assign bus.AdrSrc    = r_ctrl.adr_src & w_state_legal;
    assign bus.ALUSrcA   = r_ctrl.alu_src_a & {2{w_state_legal}};
    assign bus.ALUSrcB   = r_ctrl.alu_src_b & {2{w_state_legal}};
    assign bus.ResultSrc = r_ctrl.result_src & {2{w_state_legal}};
    assign bus.ALUOp     = r_ctrl.alu_op & w_state_legal;
    assign bus.RegW      = r_ctrl.reg_w & w_state_legal;
    assign bus.MemW      = r_ctrl.mem_w & w_state_legal;
    assign bus.Branch    = r_ctrl.branch & w_state_legal;

    a_no_wr_collision: assert property (@(posedge clk) disable iff (reset)
        !(bus.RegW && bus.MemW));
    a_memw_only_in_memwr: assert property (@(posedge clk) disable iff (reset)
        bus.MemW |-> (r_state == MEMWR));

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: stimulus queues the expected per-cycle response,
// a negedge monitor pops and compares; reset cases are checked directly.
module tb_main_fsm;

    typedef struct packed {
        logic [3:0] state;
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } exp_t;

    logic clk;
    logic reset;
    main_fsm_if bus ();

    main_fsm u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_step   = 0;
    logic mon_en   = 1'b0;
    exp_t sb_q[$];

    function automatic obs_t sample();
        obs_t o;
        o.state     = bus.State;
        o.irwrite   = bus.IRWrite;
        o.nextpc    = bus.NextPC;
        o.adrsrc    = bus.AdrSrc;
        o.alusrca   = bus.ALUSrcA;
        o.alusrcb   = bus.ALUSrcB;
        o.resultsrc = bus.ResultSrc;
        o.regw      = bus.RegW;
        o.memw      = bus.MemW;
        o.branch    = bus.Branch;
        o.aluop     = bus.ALUOp;
        return o;
    endfunction

    // Expected outputs per state, written from the controller's output table.
    function automatic obs_t exp_out(input int st, input logic mr);
        obs_t o;
        o = '0;
        o.state = 4'(st);
        case (st)
            0: begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
                     o.irwrite = mr; o.nextpc = mr; end
            1: begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
            2: begin o.alusrcb = 2'b01; end
            3: begin o.adrsrc = 1'b1; end
            4: begin o.resultsrc = 2'b01; o.regw = 1'b1; end
            5: begin o.adrsrc = 1'b1; o.memw = 1'b1; end
            6: begin o.aluop = 1'b1; end
            7: begin o.alusrcb = 2'b01; o.aluop = 1'b1; end
            8: begin o.regw = 1'b1; end
            9: begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.resultsrc = 2'b10;
                     o.branch = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                      name, act.state, act[12:0], exp.state, exp[12:0]);
    endtask

    // Drive one cycle of inputs (just after a rising edge) and queue what the
    // DUT must show during that cycle.
    task automatic step(input string name, input logic [1:0] op, input logic [5:0] funct,
                        input logic mr, input int exp_state);
        exp_t e;
        bus.Op       = op;
        bus.Funct    = funct;
        bus.MemReady = mr;
        e.name = $sformatf("%s_c%0d", name, n_step);
        e.exp  = exp_out(exp_state, mr);
        sb_q.push_back(e);
        n_step++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, sample(), e.exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t rst_exp;
        rst_exp = exp_out(0, 1'b0);

        reset        = 1'b0;
        bus.Op       = 2'b00;
        bus.Funct    = 6'b000000;
        bus.MemReady = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("reset_immediate", sample(), rst_exp);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_held_memready1", sample(), rst_exp);
        reset  = 1'b0;
        mon_en = 1'b1;

        // ADD register: 0,1,6,8 with garbage Op/Funct outside DECODE
        step("add", 2'b11, 6'b111111, 1'b1, 0);
        step("add", 2'b00, 6'b000100, 1'b1, 1);
        step("add", 2'b11, 6'b111111, 1'b1, 6);
        step("add", 2'b01, 6'b100001, 1'b1, 8);

        // LDR with two wait cycles in MEMRD
        step("ldr", 2'b10, 6'b000000, 1'b1, 0);
        step("ldr", 2'b01, 6'b000001, 1'b1, 1);
        step("ldr", 2'b01, 6'b000001, 1'b1, 2);
        step("ldr", 2'b00, 6'b000000, 1'b0, 3);
        step("ldr", 2'b00, 6'b100000, 1'b0, 3);
        step("ldr", 2'b10, 6'b000000, 1'b1, 3);
        step("ldr", 2'b00, 6'b000000, 1'b1, 4);

        // STR with one wait cycle in MEMWR
        step("str", 2'b00, 6'b000000, 1'b1, 0);
        step("str", 2'b01, 6'b000000, 1'b1, 1);
        step("str", 2'b01, 6'b100000, 1'b1, 2);
        step("str", 2'b11, 6'b000001, 1'b0, 5);
        step("str", 2'b00, 6'b000000, 1'b1, 5);

        // B
        step("b", 2'b00, 6'b000000, 1'b1, 0);
        step("b", 2'b10, 6'b000000, 1'b1, 1);
        step("b", 2'b00, 6'b000001, 1'b1, 9);

        // FETCH stall for three cycles, then undefined opcode
        step("fwait", 2'b00, 6'b000000, 1'b0, 0);
        step("fwait", 2'b01, 6'b000001, 1'b0, 0);
        step("fwait", 2'b10, 6'b100000, 1'b0, 0);
        step("fwait", 2'b00, 6'b000000, 1'b1, 0);
        step("undef", 2'b11, 6'b100001, 1'b1, 1);

        // Data-processing immediate
        step("addi", 2'b00, 6'b000000, 1'b1, 0);
        step("addi", 2'b00, 6'b101000, 1'b1, 1);
        step("addi", 2'b00, 6'b000000, 1'b1, 7);
        step("addi", 2'b00, 6'b000000, 1'b1, 8);

        // STR stalled in MEMWR, aborted by an asynchronous reset
        step("abort", 2'b00, 6'b000000, 1'b1, 0);
        step("abort", 2'b01, 6'b000000, 1'b1, 1);
        step("abort", 2'b01, 6'b000000, 1'b1, 2);
        step("abort", 2'b00, 6'b000000, 1'b0, 5);
        step("abort", 2'b00, 6'b000000, 1'b0, 5);
        mon_en = 1'b0;
        #1;
        check("memwr_before_reset", sample(), exp_out(5, 1'b0));
        #1 reset = 1'b1;
        #1;
        check("reset_async_in_memwr", sample(), rst_exp);
        bus.MemReady = 1'b1;
        @(posedge clk); #1;
        check("reset_held_after_edge", sample(), rst_exp);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Recovery: STR completing without waits
        step("recover", 2'b00, 6'b000000, 1'b1, 0);
        step("recover", 2'b01, 6'b000000, 1'b1, 1);
        step("recover", 2'b01, 6'b000000, 1'b1, 2);
        step("recover", 2'b00, 6'b000000, 1'b1, 5);
        step("recover", 2'b00, 6'b000000, 1'b0, 0);

        @(posedge clk); #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port Op, input, 2 bits: instruction bits [27:26].
REQ-004 The block SHALL have the port Funct, input, 6 bits: instruction bits [25:20]; Funct[5] is the immediate bit and Funct[0] is the load/store L bit.
REQ-005 The block SHALL have the port MemReady, input, 1 bit: memory completion handshake for the current access.
REQ-006 The block SHALL have the port State, output, 4 bits: current state encoding, for debug.
REQ-007 The block SHALL have the 1-bit outputs IRWrite, AdrSrc, NextPC, RegW, MemW, Branch and ALUOp: datapath and condition-logic enables and selects.
REQ-008 The block SHALL have the 2-bit outputs ALUSrcA, ALUSrcB and ResultSrc: datapath mux selects.

Function
REQ-009 The block SHALL implement a Moore FSM with the encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8 and BRANCH=9; the State output SHALL equal this encoding.
REQ-010 In FETCH the FSM SHALL go to DECODE when MemReady=1 and SHALL stay in FETCH otherwise.
REQ-011 In DECODE the FSM SHALL go to EXECUTER on Op=00 with Funct[5]=0, to EXECUTEI on Op=00 with Funct[5]=1, to MEMADR on Op=01, to BRANCH on Op=10, and to FETCH on Op=11 (undefined opcode, treated as NOP).
REQ-012 In MEMADR the FSM SHALL go to MEMRD when Funct[0]=1 and to MEMWR when Funct[0]=0.
REQ-013 In MEMRD the FSM SHALL go to MEMWB when MemReady=1 and SHALL stay in MEMRD otherwise.
REQ-014 In MEMWR the FSM SHALL go to FETCH when MemReady=1 and SHALL stay in MEMWR otherwise.
REQ-015 The FSM SHALL transition MEMWB->FETCH, EXECUTER->ALUWB, EXECUTEI->ALUWB, ALUWB->FETCH and BRANCH->FETCH unconditionally.
REQ-016 Any unused encoding (10-15) SHALL transition to FETCH on the next edge, and every output SHALL be 0 in that state.
REQ-017 FETCH outputs SHALL be AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0 and ResultSrc=10, with IRWrite=MemReady and NextPC=MemReady; these two are the only Mealy terms and guarantee a single PC increment per fetch.
REQ-018 DECODE outputs SHALL be ALUSrcA=01, ALUSrcB=10, ALUOp=0 and ResultSrc=10.
REQ-019 MEMADR outputs SHALL be ALUSrcA=00, ALUSrcB=01 and ALUOp=0.
REQ-020 MEMRD outputs SHALL be AdrSrc=1 and ResultSrc=00.
REQ-021 MEMWB outputs SHALL be ResultSrc=01 and RegW=1.
REQ-022 MEMWR outputs SHALL be AdrSrc=1 and MemW=1, with MemW held on every cycle spent in MEMWR including wait cycles.
REQ-023 EXECUTER outputs SHALL be ALUSrcA=00, ALUSrcB=00 and ALUOp=1.
REQ-024 EXECUTEI outputs SHALL be ALUSrcA=00, ALUSrcB=01 and ALUOp=1.
REQ-025 ALUWB outputs SHALL be ResultSrc=00 and RegW=1.
REQ-026 BRANCH outputs SHALL be ALUSrcA=10, ALUSrcB=01, ALUOp=0, ResultSrc=10 and Branch=1.
REQ-027 Every output not listed for a state SHALL be 0, and every 2-bit select not listed SHALL be 00.
REQ-028 Op and Funct SHALL be sampled only in DECODE and MEMADR and SHALL be ignored in all other states.
REQ-029 With MemReady held at 1, instruction latency SHALL be: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 2.
REQ-030 Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency and SHALL change no output.

Reset
REQ-031 While reset=1 the state SHALL be FETCH immediately, without waiting for a clock edge.
REQ-032 While reset=1, IRWrite, NextPC, RegW, MemW and Branch SHALL be forced to 0 and the remaining outputs SHALL take their FETCH values.
REQ-033 A reset asserted in any state, including mid-wait in MEMRD or MEMWR, SHALL abort the instruction with no further RegW or MemW pulse.
REQ-034 After reset deasserts, the first rising edge SHALL evaluate the FETCH transitions.

Verification
REQ-035 The bench SHALL cover: ADD register (Op=00, Funct=000100) with MemReady=1 -> State sequence 0,1,6,8,0 with RegW=1 only in the state-8 cycle.
REQ-036 The bench SHALL cover: LDR (Op=01, Funct[0]=1) with MemReady=0 for 2 cycles in MEMRD -> State sequence 0,1,2,3,3,3,4,0, AdrSrc=1 throughout state 3, RegW=1 in state 4 only.
REQ-037 The bench SHALL cover: STR (Op=01, Funct[0]=0) with MemReady=0 for 1 cycle -> State sequence 0,1,2,5,5,0 with MemW=1 in both state-5 cycles.
REQ-038 The bench SHALL cover: B (Op=10) -> State sequence 0,1,9,0 with Branch=1 and ALUSrcA=10 in state 9.
REQ-039 The bench SHALL cover: FETCH with MemReady=0 for 3 cycles -> IRWrite=0, NextPC=0 and State=0 throughout, then IRWrite=1 and NextPC=1 for exactly one cycle.
REQ-040 The bench SHALL cover: reset asserted asynchronously (between clock edges) while in MEMWR -> State=0 and MemW=0 before the next clock edge, and Op=11 decoding -> State sequence 0,1,0.
